// File: rtl/ldmx_axil_pkg.sv
// Shared AXI-Lite response codes, merge FSM encoding and DPM channel map.
package ldmx_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD_STB,
    RD_RESP,
    WR_STB,
    WR_RESP
  } state_t;

  // Channel indices used by the DPM application top
  localparam int CH_FC = 0;
  localparam int CH_GT = 1;
  localparam int CH_WB = 2;

  // True for any response that should be counted as an error
  function automatic logic is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/strobe_timer.sv
// Strobe wait counter: cleared while no strobe is up, counts while one is,
// and flags the last permitted strobe cycle.
module strobe_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic axilClk,
  input  logic axilRst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

  logic [15:0] count_q;

  // Count strobe cycles; hold once the final cycle is reached
  always_ff @(posedge axilClk) begin
    if (axilRst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && !expired) begin
      count_q <= count_q + 16'd1;
    end
  end

  // count_q is k-1 during the k-th strobe cycle, so this marks cycle TIMEOUT
  assign expired = (count_q == LAST);

endmodule

// File: rtl/axil_strobe_merge.sv
// AXI-Lite slave that turns single register accesses into one-hot
// strobe/ack handshakes on NUM_CH downstream register ports.
module axil_strobe_merge
  import ldmx_axil_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int CH_LSB  = 10,
  parameter int CH_W    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   axilClk,
  input  logic                   axilRst,
  input  logic [31:0]            axilReadMaster_araddr,
  input  logic                   axilReadMaster_arvalid,
  output logic                   axilReadSlave_arready,
  output logic [31:0]            axilReadSlave_rdata,
  output logic [1:0]             axilReadSlave_rresp,
  output logic                   axilReadSlave_rvalid,
  input  logic                   axilReadMaster_rready,
  input  logic [31:0]            axilWriteMaster_awaddr,
  input  logic                   axilWriteMaster_awvalid,
  input  logic [31:0]            axilWriteMaster_wdata,
  input  logic                   axilWriteMaster_wvalid,
  input  logic                   axilWriteMaster_bready,
  output logic                   axilWriteSlave_awready,
  output logic                   axilWriteSlave_wready,
  output logic [1:0]             axilWriteSlave_bresp,
  output logic                   axilWriteSlave_bvalid,
  output logic [7:0]             ch_raddr,
  output logic [7:0]             ch_waddr,
  output logic [31:0]            ch_din,
  output logic [NUM_CH-1:0]      ch_rstr,
  output logic [NUM_CH-1:0]      ch_wstr,
  input  logic [NUM_CH-1:0]      ch_rack,
  input  logic [NUM_CH-1:0]      ch_wack,
  input  logic [32*NUM_CH-1:0]   ch_dout,
  output logic [15:0]            err_count
);

  localparam logic [31:0] NUM_CH_U = NUM_CH;

  state_t              state_q;
  logic                last_rd_q;
  logic                dec_wait_q;
  logic                stb_on_q;
  logic [CH_W-1:0]     idx_q;
  logic                arready_q;
  logic                awready_q;
  logic                rvalid_q;
  logic                bvalid_q;
  logic [31:0]         rdata_q;
  logic [1:0]          rresp_q;
  logic [1:0]          bresp_q;
  logic [7:0]          raddr_q;
  logic [7:0]          waddr_q;
  logic [31:0]         din_q;
  logic [NUM_CH-1:0]   rstr_q;
  logic [NUM_CH-1:0]   wstr_q;
  logic [15:0]         err_q;

  logic [CH_W-1:0]     ar_idx;
  logic [CH_W-1:0]     aw_idx;
  logic                ar_mapped;
  logic                aw_mapped;
  logic                rd_req;
  logic                wr_req;
  logic                take_rd;
  logic                take_wr;
  logic [NUM_CH-1:0]   sel_oh;
  logic [31:0]         sel_dout;
  logic                sel_rack;
  logic                sel_wack;
  logic                tmr_exp;
  logic                unused_addr_bits;

  // Only the channel field and word offset of the addresses are decoded
  assign unused_addr_bits = ^{axilReadMaster_araddr, axilWriteMaster_awaddr};

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  strobe_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .axilClk (axilClk),
    .axilRst (axilRst),
    .clr     (!stb_on_q),
    .en      (stb_on_q),
    .expired (tmr_exp)
  );

  // Request arbitration, address decode and selected-channel muxing
  always_comb begin
    ar_idx    = axilReadMaster_araddr[CH_LSB +: CH_W];
    aw_idx    = axilWriteMaster_awaddr[CH_LSB +: CH_W];
    ar_mapped = {{(32-CH_W){1'b0}}, ar_idx} < NUM_CH_U;
    aw_mapped = {{(32-CH_W){1'b0}}, aw_idx} < NUM_CH_U;
    rd_req    = axilReadMaster_arvalid;
    wr_req    = axilWriteMaster_awvalid && axilWriteMaster_wvalid;
    // When both are pending, the type not served last wins
    take_rd   = rd_req && (!wr_req || !last_rd_q);
    take_wr   = wr_req && !take_rd;
    sel_oh    = '0;
    sel_dout  = '0;
    sel_rack  = 1'b0;
    sel_wack  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx_q == CH_W'(k)) begin
        sel_oh[k] = 1'b1;
        sel_dout  = ch_dout[32*k +: 32];
        sel_rack  = ch_rack[k];
        sel_wack  = ch_wack[k];
      end
    end
  end

  // Access FSM: accept, strobe until ack or timeout, hold response
  always_ff @(posedge axilClk) begin
    if (axilRst) begin
      state_q    <= IDLE;
      last_rd_q  <= 1'b0;
      dec_wait_q <= 1'b0;
      stb_on_q   <= 1'b0;
      idx_q      <= '0;
      arready_q  <= 1'b0;
      awready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      bresp_q    <= RESP_OKAY;
      raddr_q    <= '0;
      waddr_q    <= '0;
      din_q      <= '0;
      rstr_q     <= '0;
      wstr_q     <= '0;
      err_q      <= '0;
    end else begin
      arready_q <= 1'b0;
      awready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (take_rd) begin
            arready_q <= 1'b1;
            last_rd_q <= 1'b1;
            raddr_q   <= axilReadMaster_araddr[9:2];
            idx_q     <= ar_idx;
            rdata_q   <= '0;
            if (ar_mapped) begin
              state_q <= RD_STB;
            end else begin
              rresp_q    <= RESP_DECERR;
              dec_wait_q <= 1'b1;
              state_q    <= RD_RESP;
            end
          end else if (take_wr) begin
            awready_q <= 1'b1;
            last_rd_q <= 1'b0;
            waddr_q   <= axilWriteMaster_awaddr[9:2];
            din_q     <= axilWriteMaster_wdata;
            idx_q     <= aw_idx;
            if (aw_mapped) begin
              state_q <= WR_STB;
            end else begin
              bresp_q    <= RESP_DECERR;
              dec_wait_q <= 1'b1;
              state_q    <= WR_RESP;
            end
          end
        end
        RD_STB: begin
          if (!stb_on_q) begin
            rstr_q   <= sel_oh;
            stb_on_q <= 1'b1;
          end else if (sel_rack) begin
            rstr_q   <= '0;
            stb_on_q <= 1'b0;
            rdata_q  <= sel_dout;
            rresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b1;
            state_q  <= RD_RESP;
          end else if (tmr_exp) begin
            rstr_q   <= '0;
            stb_on_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_SLVERR;
            rvalid_q <= 1'b1;
            err_q    <= sat_inc(err_q);
            state_q  <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (!rvalid_q) begin
            // Unmapped access: one spacer cycle, then present DECERR
            if (dec_wait_q) begin
              dec_wait_q <= 1'b0;
            end else begin
              rvalid_q <= 1'b1;
              if (is_err(rresp_q)) err_q <= sat_inc(err_q);
            end
          end else if (axilReadMaster_rready) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        WR_STB: begin
          if (!stb_on_q) begin
            wstr_q   <= sel_oh;
            stb_on_q <= 1'b1;
          end else if (sel_wack) begin
            wstr_q   <= '0;
            stb_on_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            bvalid_q <= 1'b1;
            state_q  <= WR_RESP;
          end else if (tmr_exp) begin
            wstr_q   <= '0;
            stb_on_q <= 1'b0;
            bresp_q  <= RESP_SLVERR;
            bvalid_q <= 1'b1;
            err_q    <= sat_inc(err_q);
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (!bvalid_q) begin
            if (dec_wait_q) begin
              dec_wait_q <= 1'b0;
            end else begin
              bvalid_q <= 1'b1;
              if (is_err(bresp_q)) err_q <= sat_inc(err_q);
            end
          end else if (axilWriteMaster_bready) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign axilReadSlave_arready  = arready_q;
  assign axilReadSlave_rdata    = rdata_q;
  assign axilReadSlave_rresp    = rresp_q;
  assign axilReadSlave_rvalid   = rvalid_q;
  assign axilWriteSlave_awready = awready_q;
  assign axilWriteSlave_wready  = awready_q;
  assign axilWriteSlave_bresp   = bresp_q;
  assign axilWriteSlave_bvalid  = bvalid_q;
  assign ch_raddr               = raddr_q;
  assign ch_waddr               = waddr_q;
  assign ch_din                 = din_q;
  assign ch_rstr                = rstr_q;
  assign ch_wstr                = wstr_q;
  assign err_count              = err_q;

endmodule

// File: tb/tb_axil_strobe_merge.sv
// Randomized scoreboard bench for axil_strobe_merge.
module tb_axil_strobe_merge;

  localparam int NUM_CH  = 3;
  localparam int TIMEOUT = 8;
  localparam int NEVER   = 1000;

  logic                  axilClk = 1'b0;
  logic                  axilRst;
  logic [31:0]           araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;
  logic [31:0]           awaddr;
  logic                  awvalid;
  logic [31:0]           wdata;
  logic                  wvalid;
  logic                  bready;
  logic                  awready;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic [7:0]            ch_raddr;
  logic [7:0]            ch_waddr;
  logic [31:0]           ch_din;
  logic [NUM_CH-1:0]     ch_rstr;
  logic [NUM_CH-1:0]     ch_wstr;
  logic [NUM_CH-1:0]     ch_rack;
  logic [NUM_CH-1:0]     ch_wack;
  logic [32*NUM_CH-1:0]  ch_dout;
  logic [15:0]           err_count;

  axil_strobe_merge #(
    .NUM_CH  (NUM_CH),
    .CH_LSB  (10),
    .CH_W    (4),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .axilClk                 (axilClk),
    .axilRst                 (axilRst),
    .axilReadMaster_araddr   (araddr),
    .axilReadMaster_arvalid  (arvalid),
    .axilReadSlave_arready   (arready),
    .axilReadSlave_rdata     (rdata),
    .axilReadSlave_rresp     (rresp),
    .axilReadSlave_rvalid    (rvalid),
    .axilReadMaster_rready   (rready),
    .axilWriteMaster_awaddr  (awaddr),
    .axilWriteMaster_awvalid (awvalid),
    .axilWriteMaster_wdata   (wdata),
    .axilWriteMaster_wvalid  (wvalid),
    .axilWriteMaster_bready  (bready),
    .axilWriteSlave_awready  (awready),
    .axilWriteSlave_wready   (wready),
    .axilWriteSlave_bresp    (bresp),
    .axilWriteSlave_bvalid   (bvalid),
    .ch_raddr                (ch_raddr),
    .ch_waddr                (ch_waddr),
    .ch_din                  (ch_din),
    .ch_rstr                 (ch_rstr),
    .ch_wstr                 (ch_wstr),
    .ch_rack                 (ch_rack),
    .ch_wack                 (ch_wack),
    .ch_dout                 (ch_dout),
    .err_count               (err_count)
  );

  initial forever #5 axilClk = ~axilClk;

  typedef struct {
    bit          is_wr;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [15:0] err;
    int          events;
    int          len;
    int          ch;
    logic [7:0]  off;
    logic [31:0] din;
  } exp_t;

  exp_t sbq[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_exp = 0;
  int exp_events = 0;

  // Channel responder: ack the strobed channel after ack_delay cycles
  int ack_delay = 0;
  int stb_cnt = 0;
  logic [NUM_CH-1:0] noise = '0;
  logic [31:0] dout_arr [NUM_CH];

  always_ff @(posedge axilClk) stb_cnt <= (|{ch_rstr, ch_wstr}) ? stb_cnt + 1 : 0;

  always_comb begin
    ch_rack = noise;
    ch_wack = noise;
    ch_dout = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_rstr[k]) ch_rack[k] = (stb_cnt == ack_delay);
      if (ch_wstr[k]) ch_wack[k] = (stb_cnt == ack_delay);
      ch_dout[32*k +: 32] = dout_arr[k];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // Random ready back-pressure and noise acks on idle channels
  initial begin
    rready = 1'b1;
    bready = 1'b1;
    forever begin
      @(posedge axilClk);
      #1;
      rready = ($urandom % 4) != 0;
      bready = ($urandom % 4) != 0;
      noise  = NUM_CH'($urandom);
    end
  end

  // Strobe watcher: record each strobe burst and check one-hot
  int          stb_events = 0;
  int          stb_len = 0;
  int          stb_ch = -1;
  bit          stb_wr = 1'b0;
  logic [7:0]  stb_off = '0;
  logic [31:0] stb_din = '0;
  bit          prev_any = 1'b0;

  initial forever begin
    @(negedge axilClk);
    if (|{ch_rstr, ch_wstr}) begin
      chk("strobe_onehot", 64'($countones({ch_rstr, ch_wstr})), 64'd1);
      if (!prev_any) begin
        stb_events++;
        stb_len = 1;
        stb_wr  = |ch_wstr;
        stb_off = stb_wr ? ch_waddr : ch_raddr;
        stb_din = ch_din;
        for (int k = 0; k < NUM_CH; k++)
          if (ch_rstr[k] || ch_wstr[k]) stb_ch = k;
      end else begin
        stb_len++;
      end
      prev_any = 1'b1;
    end else begin
      prev_any = 1'b0;
    end
  end

  task automatic first_check(input bit is_wr, output exp_t e);
    if (sbq.size() == 0) begin
      fail_now(is_wr ? "unexpected_bvalid" : "unexpected_rvalid");
      e.is_wr = is_wr; e.resp = is_wr ? bresp : rresp; e.rdata = rdata;
      return;
    end
    e = sbq.pop_front();
    chk("resp_kind_is_wr", 64'(is_wr), 64'(e.is_wr));
    chk(is_wr ? "bresp" : "rresp", 64'(is_wr ? bresp : rresp), 64'(e.resp));
    if (!is_wr) chk("rdata", 64'(rdata), 64'(e.rdata));
    chk("err_count", 64'(err_count), 64'(e.err));
    chk("strobe_events", 64'(stb_events), 64'(e.events));
    if (e.len > 0) begin
      chk("strobe_len", 64'(stb_len), 64'(e.len));
      chk("strobe_ch", 64'(stb_ch), 64'(e.ch));
      chk("strobe_is_wr", 64'(stb_wr), 64'(e.is_wr));
      chk("strobe_off", 64'(stb_off), 64'(e.off));
      if (is_wr) chk("ch_din", 64'(stb_din), 64'(e.din));
      else       chk("ch_raddr_held", 64'(ch_raddr), 64'(e.off));
    end
  endtask

  // Response monitor: pop expectation on each new response, check hold
  initial begin
    exp_t cur_r, cur_w;
    bit   r_seen = 1'b0, b_seen = 1'b0;
    forever begin
      @(negedge axilClk);
      if (axilRst) begin
        r_seen = 1'b0;
        b_seen = 1'b0;
      end else begin
        if (rvalid) begin
          if (!r_seen) begin
            first_check(1'b0, cur_r);
            r_seen = 1'b1;
          end else begin
            chk("rresp_hold", 64'(rresp), 64'(cur_r.resp));
            chk("rdata_hold", 64'(rdata), 64'(cur_r.rdata));
          end
          if (rready) begin
            r_seen = 1'b0;
            done_cnt++;
          end
        end
        if (bvalid) begin
          if (!b_seen) begin
            first_check(1'b1, cur_w);
            b_seen = 1'b1;
          end else begin
            chk("bresp_hold", 64'(bresp), 64'(cur_w.resp));
          end
          if (bready) begin
            b_seen = 1'b0;
            done_cnt++;
          end
        end
      end
    end
  end

  // Reference model: outcome of one access from the mapping/timeout rules
  task automatic push_exp(input bit is_wr, input logic [31:0] addr,
                          input logic [31:0] data, input int delay);
    exp_t e;
    int idx;
    idx     = int'((addr >> 10) & 32'hF);
    e.is_wr = is_wr;
    e.off   = addr[9:2];
    e.ch    = idx;
    e.din   = data;
    if (idx >= NUM_CH) begin
      e.resp = 2'b11; e.rdata = 0; e.len = 0;
    end else if (delay < TIMEOUT) begin
      e.resp = 2'b00; e.rdata = is_wr ? 32'h0 : dout_arr[idx]; e.len = delay + 1;
    end else begin
      e.resp = 2'b10; e.rdata = 0; e.len = TIMEOUT;
    end
    if (e.resp != 2'b00 && err_exp < 65535) err_exp++;
    if (e.len > 0) exp_events++;
    e.err    = 16'(err_exp);
    e.events = exp_events;
    sbq.push_back(e);
  endtask

  task automatic wait_accept(input bit is_wr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge axilClk);
      #1;
      if (is_wr ? (awready && wready) : arready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge axilClk);
    #1;
    arvalid = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic run_access(input bit is_wr, input logic [31:0] addr,
                            input logic [31:0] data, input int delay);
    bit ok;
    int target;
    @(posedge axilClk);
    #1;
    ack_delay = delay;
    push_exp(is_wr, addr, data, delay);
    target = done_cnt + 1;
    if (is_wr) begin
      awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    end else begin
      araddr = addr; arvalid = 1'b1;
    end
    wait_accept(is_wr, ok);
    if (!ok) fail_now("accept_timeout");
    for (int i = 0; i < 200; i++) begin
      if (done_cnt >= target) break;
      @(posedge axilClk);
    end
    if (done_cnt < target) fail_now("response_timeout");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_arready"}, 64'(arready), 0);
    chk({tag, "_awready"}, 64'(awready), 0);
    chk({tag, "_wready"},  64'(wready), 0);
    chk({tag, "_rvalid"},  64'(rvalid), 0);
    chk({tag, "_bvalid"},  64'(bvalid), 0);
    chk({tag, "_strobes"}, 64'({ch_rstr, ch_wstr}), 0);
    chk({tag, "_resps"},   64'({rresp, bresp}), 0);
    chk({tag, "_rdata"},   64'(rdata), 0);
    chk({tag, "_addrs"},   64'({ch_raddr, ch_waddr}), 0);
    chk({tag, "_din"},     64'(ch_din), 0);
    chk({tag, "_err"},     64'(err_count), 0);
  endtask

  initial begin
    bit ok;
    int n;
    int target;
    axilRst = 1'b1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    araddr = '0; awaddr = '0; wdata = '0;
    for (int k = 0; k < NUM_CH; k++) dout_arr[k] = $urandom;
    repeat (3) @(posedge axilClk);
    #1;
    check_reset_outputs("reset");
    axilRst = 1'b0;

    // Directed: read OK, write OK, DECERR, timeout, ack on last cycle
    dout_arr[1] = 32'hCAFE_0001;
    run_access(1'b0, 32'h0000_0404, 32'h0, 2);
    run_access(1'b1, 32'h0000_0808, 32'h1234_5678, 0);
    run_access(1'b0, 32'h0000_0C00, 32'h0, 0);
    run_access(1'b0, 32'h0000_0010, 32'h0, NEVER);
    run_access(1'b1, 32'h0000_0824, 32'hA5A5_0F0F, TIMEOUT - 1);
    run_access(1'b1, 32'h0000_3C00, 32'h0BAD_0BAD, 0);

    // Randomized accesses across mapped and unmapped channels
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int ch, dly;
      ch  = (($urandom % 8) < 6) ? int'($urandom % NUM_CH) : int'($urandom_range(NUM_CH, 15));
      dly = (($urandom % 10) == 0) ? NEVER : int'($urandom_range(0, TIMEOUT));
      a   = ($urandom & 32'hFFFF_C003) | (32'(ch) << 10) | (32'($urandom % 256) << 2);
      if (ch < NUM_CH) dout_arr[ch] = $urandom;
      run_access(1'($urandom % 2), a, $urandom, dly);
    end

    // Reset during a strobe: everything drops, no response follows
    @(posedge axilClk);
    #1;
    ack_delay = NEVER;
    araddr = 32'h0000_041C;
    arvalid = 1'b1;
    wait_accept(1'b0, ok);
    if (!ok) fail_now("abort_accept_timeout");
    exp_events++;
    for (int i = 0; i < 20 && stb_cnt < 3; i++) begin
      @(posedge axilClk);
      #1;
    end
    if (stb_cnt < 3) fail_now("abort_strobe_timeout");
    axilRst = 1'b1;
    @(posedge axilClk);
    #1;
    check_reset_outputs("midreset");
    axilRst = 1'b0;
    err_exp = 0;
    repeat (30) @(posedge axilClk);

    // Fairness: all requests held, order must be R, W, R, W
    #1;
    ack_delay = 0;
    dout_arr[0] = 32'h0F0F_1111;
    araddr = 32'h0000_000C;
    awaddr = 32'h0000_0414;
    wdata  = 32'h7777_2222;
    target = done_cnt + 4;
    push_exp(1'b0, araddr, 32'h0, 0);
    push_exp(1'b1, awaddr, wdata, 0);
    push_exp(1'b0, araddr, 32'h0, 0);
    push_exp(1'b1, awaddr, wdata, 0);
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      @(posedge axilClk);
      #1;
      if (arready) n++;
      if (awready) n++;
    end
    @(posedge axilClk);
    #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    if (n < 4) fail_now("fairness_accepts");
    for (int i = 0; i < 200; i++) begin
      if (done_cnt >= target) break;
      @(posedge axilClk);
    end
    if (done_cnt < target) fail_now("fairness_responses");

    repeat (10) @(posedge axilClk);
    chk("scoreboard_empty", 64'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_strobe_merge.md
# axil_strobe_merge

Parametrised AXI-Lite slave that decodes register accesses onto NUM_CH strobe/acknowledge register ports (fast control, optical link, wishbone bridge and later additions) inside the DPM application top. It generalises the fixed three-port merge with a configurable channel count. It also adds read/write fairness, a per-access timeout with SLVERR, DECERR for unmapped channels, and a saturating error counter.

## Interface
Parameters:
- NUM_CH, 3: number of downstream register ports (1..16).
- CH_LSB, 10: byte-address bit where the channel index field starts.
- CH_W, 4: channel index field width; index = addr[CH_LSB +: CH_W].
- TIMEOUT, 255: cycles a strobe may wait for ack (1..65535).

Ports:
- axilClk  in  1  sole clock; all logic on the rising edge.
- axilRst  in  1  reset, synchronous, active-high.
- axilReadMaster_araddr / _arvalid  in  32/1  AR channel.
- axilReadSlave_arready  out  1.
- axilReadSlave_rdata / _rresp / _rvalid  out  32/2/1.
- axilReadMaster_rready  in  1.
- axilWriteMaster_awaddr / _awvalid / _wdata / _wvalid / _bready  in  32/1/32/1/1.
- axilWriteSlave_awready / _wready / _bresp / _bvalid  out  1/1/2/1.
- ch_raddr / ch_waddr  out  8  word offset, addr[9:2], held for the whole access.
- ch_din  out  32  latched write data.
- ch_rstr / ch_wstr  out  NUM_CH  one-hot read/write strobes.
- ch_rack / ch_wack  in  NUM_CH  acknowledges.
- ch_dout  in  32*NUM_CH  read data; channel k occupies [32k+31:32k].
- err_count  out  16  saturating count of SLVERR and DECERR responses.

## Operation
- FSM states: IDLE, RD_STB, RD_RESP, WR_STB, WR_RESP.
- **IDLE, read pending** (arvalid): pulse arready for 1 cycle and latch address.
- **IDLE, write pending** (awvalid and wvalid both high): pulse awready and wready together for 1 cycle and latch address and data. AW without W is not accepted.
- **Both pending:** serve the type not served last. The last_rd flag resets to 0, so a read wins first after reset.
- **Decode:** if index >= NUM_CH, no strobe is raised. Go directly to the RESP state with resp=DECERR (2'b11) and rdata=0.
- **RD_STB / WR_STB:** hold the selected strobe high and count cycles.
  - Ack sampled high: drop the strobe and capture ch_dout[index] (read). Go to RESP with OKAY (2'b00).
  - Count reaches TIMEOUT with no ack: drop the strobe and go to RESP with SLVERR (2'b10), rdata=0.
- **RD_RESP / WR_RESP:** hold rvalid/bvalid with stable data/resp until rready/bready is sampled high, then return to IDLE.
- **err_count:** increments on each SLVERR or DECERR response and saturates at 0xFFFF.
- **Unsupported inputs:** arprot, awprot and wstrb are ignored; full 32-bit writes only.

## Timing
- **Reset values:** all ready/valid/strobe outputs 0, rresp/bresp 0, rdata 0, ch_raddr/ch_waddr/ch_din 0, err_count 0, state IDLE.
- **Read latency:**
  - arvalid sampled in IDLE at edge N: arready is high for cycle N+1.
  - Strobe rises at N+2.
  - Ack sampled at edge M: rvalid rises at M+1.
  - Minimum arvalid-to-rvalid is 3 cycles when ack is combinational.
- **Write latency:** identical, using awready/wready and bvalid.
- **DECERR:** the response is valid 2 cycles after the accept pulse.
- **Timeout:** the strobe stays high for exactly TIMEOUT cycles. SLVERR is valid the following cycle.
- **Ack rules:** an ack arriving in the same cycle as the timeout expiry counts as a success. Acks on non-selected channels are ignored.
- **No overlap:** at most one strobe is high in any cycle, and at most one access is outstanding.
- **Reset mid-access:** strobes and valids drop at the next edge, no response is issued, and the FSM returns to IDLE.

## Structure
- **Package ldmx_axil_pkg:** resp constants (RESP_OKAY, RESP_SLVERR, RESP_DECERR), the FSM state encoding, and the DPM channel index constants (CH_FC=0, CH_GT=1, CH_WB=2).
- **Sub-module strobe_timer:** 16-bit counter with clear, enable and an expired flag compared against TIMEOUT, shared by both STB states.

## Test plan
- **Read OK:** read 0x0000_0404 with ch_rack[1] high 2 cycles after ch_rstr[1], ch_dout[1]=0xCAFE_0001.
  - Expect ch_raddr=0x01, rdata=0xCAFE_0001, rresp=0, rvalid held until rready.
- **Write OK:** write 0x0000_0808 with data 0x1234_5678, ch_wack[2] immediate.
  - Expect ch_waddr=0x02, ch_din=0x1234_5678, bresp=0, exactly 1 strobe cycle.
- **DECERR:** NUM_CH=3, read 0x0000_0C00.
  - Expect no strobe, rresp=2'b11, rdata=0, err_count=1.
- **Timeout:** TIMEOUT=8, ack never asserted.
  - Expect the strobe high exactly 8 cycles, then SLVERR and err_count increment.
  - Repeat with the ack on the 8th cycle: expect OKAY.
- **Fairness:** arvalid, awvalid and wvalid all held continuously.
  - Expect the serving order R, W, R, W after reset.
  - Assert reset mid-strobe: expect all outputs at reset values next cycle and no stale response afterwards.
